tff_counter: RTL and testbench

Parametrised synchronous counter/toggle register built on the T flip-flop primitive: WIDTH toggle cells share one clock and one asynchronous clear. Supports up-count, down-count and raw per-bit toggle modes, modulo wrap, parallel load, and wrap/terminal-count flags. It is the multi-bit, mode-selectable successor to the single-bit T flip-flop. Intended for timers, dividers and event counters in the same designs.

---
 rtl/tff_counter.sv | 139 +++++++++++++
 tb/tb_tff_counter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/tff_counter.sv
// tff_counter: mode-selectable up/down/raw-toggle counter built from T flip-flop cells.
// The next state is computed centrally and each cell is fed t = q ^ next,
// so every bit still updates only by toggling.
// Optional build macro: TFF_CNT_SAT_EN gives saturating up/down with no wrap.

module tff_cell (
  input  logic clk,
  input  logic clear,
  input  logic t,
  output logic q
);

  logic r_q;

  // Toggle on t, with asynchronous clear to 0.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear)  r_q <= 1'b0;
    else if (t)  r_q <= ~r_q;
  end

  assign q = r_q;

endmodule

module tff_counter #(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t_mask,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             err
);

  localparam logic [1:0] M_HOLD = 2'b00;
  localparam logic [1:0] M_UP   = 2'b01;
  localparam logic [1:0] M_DOWN = 2'b10;
  localparam logic [1:0] M_TOG  = 2'b11;

  // Largest in-range count. Comparing against this in WIDTH bits avoids
  // needing a WIDTH+1 bit copy of MODULUS when MODULUS == 2**WIDTH.
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_t;
  logic             w_wrap_nxt;
  logic             w_err_nxt;
  logic             r_wrap;
  logic             r_err;

  // Next-state selection: load beats enable; enable with mode picks the step.
  always_comb begin
    w_next     = w_q;
    w_wrap_nxt = 1'b0;
    w_err_nxt  = 1'b0;
    if (load) begin
      if (load_val > MAX) begin
        w_next    = MAX;
        w_err_nxt = 1'b1;
      end else begin
        w_next = load_val;
      end
    end else if (en) begin
      case (mode)
        M_UP: begin
          if (w_q >= MAX) begin
`ifdef TFF_CNT_SAT_EN
            w_next = MAX;
`else
            w_next     = '0;
            w_wrap_nxt = 1'b1;
`endif
          end else begin
            w_next = w_q + WIDTH'(1);
          end
        end
        M_DOWN: begin
          if (w_q == '0) begin
`ifdef TFF_CNT_SAT_EN
            w_next = '0;
`else
            w_next     = MAX;
            w_wrap_nxt = 1'b1;
`endif
          end else if (w_q > MAX) begin
            // Out-of-range value left by a raw toggle snaps back into range.
            w_next = MAX;
          end else begin
            w_next = w_q - WIDTH'(1);
          end
        end
        M_TOG:   w_next = w_q ^ t_mask;
        default: w_next = w_q;
      endcase
    end
  end

  assign w_t = w_q ^ w_next;

  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_cell
      tff_cell u_cell (
        .clk   (clk),
        .clear (clear),
        .t     (w_t[g]),
        .q     (w_q[g])
      );
    end
  endgenerate

  // Event flags are one-cycle pulses reflecting the previous edge's action.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_wrap <= w_wrap_nxt;
      r_err  <= w_err_nxt;
    end
  end

  assign q    = w_q;
  assign tc   = ((mode == M_UP) && (w_q >= MAX)) || ((mode == M_DOWN) && (w_q == '0));
  assign wrap = r_wrap;
  assign err  = r_err;

  logic w_unused;
  assign w_unused = (mode == M_HOLD);

endmodule

// File: tb/tb_tff_counter.sv
// Directed bench for tff_counter, WIDTH=4, MODULUS=10, default (modulo) build.
module tb_tff_counter;

  logic       clk;
  logic       clear;
  logic       en;
  logic [1:0] mode;
  logic [3:0] t_mask;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       tc;
  logic       wrap;
  logic       err;

  int checks = 0;
  int errors = 0;
  int wrap_cnt;

  tff_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk      (clk),
    .clear    (clear),
    .en       (en),
    .mode     (mode),
    .t_mask   (t_mask),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .tc       (tc),
    .wrap     (wrap),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear = 1'b0; en = 1'b0; mode = 2'b00; t_mask = 4'h0; load = 1'b0; load_val = 4'h0;
    #2;
    chk("rst_q", 32'(q), 0);
    chk("rst_wrap", 32'(wrap), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_tc_m0", 32'(tc), 0);
    mode = 2'b10; #1;
    chk("rst_tc_m2", 32'(tc), 1);
    step();
    clear = 1'b1;

    // Load 6, count to 7, then clear between edges.
    load = 1'b1; load_val = 4'd6; mode = 2'b01; en = 1'b1;
    step(); chk("ld6_q", 32'(q), 6);
    load = 1'b0;
    step(); chk("up7_q", 32'(q), 7);
    #2; clear = 1'b0; #1;
    chk("async_clr_q", 32'(q), 0);
    chk("async_clr_wrap", 32'(wrap), 0);
    #2; clear = 1'b1;
    step(); chk("rec_q1", 32'(q), 1);
    step(); chk("rec_q2", 32'(q), 2);
    step(); chk("rec_q3", 32'(q), 3);

    // Up wrap from 8.
    load = 1'b1; load_val = 4'd8;
    step(); chk("ld8_q", 32'(q), 8);
    load = 1'b0;
    step(); chk("up9_q", 32'(q), 9); chk("up9_tc", 32'(tc), 1); chk("up9_wrap", 32'(wrap), 0);
    step(); chk("upwrap_q", 32'(q), 0); chk("upwrap_wrap", 32'(wrap), 1); chk("upwrap_tc", 32'(tc), 0);
    step(); chk("upafter_q", 32'(q), 1); chk("upafter_wrap", 32'(wrap), 0);
    wrap_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      wrap_cnt += int'(wrap);
    end
    chk("up20_wraps", 32'(wrap_cnt), 2);
    chk("up20_q", 32'(q), 1);

    // Down wrap from 1.
    load = 1'b1; load_val = 4'd1; mode = 2'b10;
    step(); chk("ld1_q", 32'(q), 1);
    load = 1'b0;
    step(); chk("dn0_q", 32'(q), 0); chk("dn0_tc", 32'(tc), 1); chk("dn0_wrap", 32'(wrap), 0);
    step(); chk("dnwrap_q", 32'(q), 9); chk("dnwrap_wrap", 32'(wrap), 1); chk("dnwrap_tc", 32'(tc), 0);
    step(); chk("dn8_q", 32'(q), 8); chk("dn8_wrap", 32'(wrap), 0);

    // Raw toggle to out-of-range, then recover up and down.
    load = 1'b1; load_val = 4'd0;
    step(); chk("ld0_q", 32'(q), 0);
    load = 1'b0; mode = 2'b11; t_mask = 4'b1111;
    step(); chk("tog_q", 32'(q), 15); chk("tog_tc", 32'(tc), 0); chk("tog_wrap", 32'(wrap), 0);
    mode = 2'b01; #1;
    chk("oor_up_tc", 32'(tc), 1);
    step(); chk("oor_up_q", 32'(q), 0); chk("oor_up_wrap", 32'(wrap), 1);
    mode = 2'b11; t_mask = 4'b1010;
    step(); chk("tog_a_q", 32'(q), 10);
    t_mask = 4'b0101;
    step(); chk("tog_f_q", 32'(q), 15);
    mode = 2'b10;
    step(); chk("oor_dn_q", 32'(q), 9); chk("oor_dn_wrap", 32'(wrap), 0);

    // Load priority and clamp.
    load = 1'b1; en = 1'b1; mode = 2'b01; load_val = 4'd12;
    step(); chk("clamp_q", 32'(q), 9); chk("clamp_err", 32'(err), 1); chk("clamp_wrap", 32'(wrap), 0);
    load_val = 4'd5;
    step(); chk("ld5_q", 32'(q), 5); chk("ld5_err", 32'(err), 0);
    load_val = 4'd15;
    step(); chk("clamp15_q", 32'(q), 9); chk("clamp15_err", 32'(err), 1);
    load = 1'b0; en = 1'b0;
    step(); chk("err_pulse_q", 32'(q), 9); chk("err_pulse_err", 32'(err), 0);

    // Hold at q=0 with random mode/t_mask.
    load = 1'b1; load_val = 4'd0;
    step(); chk("ld0b_q", 32'(q), 0);
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mode   = 2'($urandom_range(0, 3));
      t_mask = 4'($urandom_range(0, 15));
      step();
      chk("hold_q", 32'(q), 0);
      chk("hold_wrap", 32'(wrap), 0);
      chk("hold_err", 32'(err), 0);
      chk("hold_tc", 32'(tc), (mode == 2'b10) ? 1 : 0);
    end

    // Clear coincident with a load wins.
    load = 1'b1; load_val = 4'd5; en = 1'b1; mode = 2'b01;
    #2; clear = 1'b0;
    step(); chk("clr_vs_load_q", 32'(q), 0);
    clear = 1'b1;
    step(); chk("post_clr_load_q", 32'(q), 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
